// File: rtl/ltc_reader.sv
// ltc_reader: SMPTE LTC biphase-mark decoder. Measures the time between line
// transitions, rebuilds the 80-bit frame and presents BCD time fields once a
// full frame sits between two sync words.
module ltc_reader #(
  parameter int CLK_HZ = 10_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       timecode,
  output logic [5:0] hours,
  output logic [6:0] minutes,
  output logic [6:0] seconds,
  output logic [5:0] frames,
  output logic       drop_frame,
  output logic       frame_valid,
  output logic       locked
);

  // Interval thresholds in clk cycles: shorter than T_MIN is noise, below
  // T_TH is a half cell, otherwise a full cell. T_OUT is a dead line.
  localparam logic [15:0] T_MIN     = 16'(CLK_HZ / 10000);
  localparam logic [15:0] T_TH      = 16'(CLK_HZ / 3000);
  localparam logic [15:0] T_OUT     = 16'(CLK_HZ / 960);
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;
  // LTC bits 79..64 as they sit in the shift register after a full frame
  localparam logic [15:0] SYNC_WORD = 16'hBFFC;
  localparam logic [6:0]  BIT_SAT   = 7'd127;
  localparam logic [6:0]  FRAME_LEN = 7'd80;
  localparam logic [6:0]  OVERRUN   = 7'd81;

  typedef enum logic {
    S_BIT,
    S_HALF
  } state_t;

  logic [2:0]  sync_reg;
  logic        edge_reg;
  logic [15:0] interval_reg;
  state_t      state_reg;
  logic [6:0]  bit_cnt_reg;
  logic [79:0] sr_reg;

  logic        is_glitch;
  logic        is_short;
  logic        is_long;
  logic        timeout;
  logic        shift_en;
  logic        shift_bit;
  logic        bit_error;
  logic        sync_hit;
  logic [6:0]  bit_cnt_next;
  logic [79:0] sr_next;

  assign is_glitch = interval_reg < T_MIN;
  assign is_short  = !is_glitch && (interval_reg < T_TH);
  assign is_long   = interval_reg >= T_TH;
  // interval_reg only sits at T_OUT for one cycle, so this fires once per dead spell
  assign timeout   = !edge_reg && (interval_reg == T_OUT);

  // Classify each edge strobe against the current half/whole cell position
  always_comb begin
    shift_en  = 1'b0;
    shift_bit = 1'b0;
    bit_error = timeout;
    if (edge_reg) begin
      if (is_glitch) begin
        bit_error = 1'b1;
      end else if (state_reg == S_BIT) begin
        shift_en = is_long;
      end else if (is_short) begin
        shift_en  = 1'b1;
        shift_bit = 1'b1;
      end else begin
        bit_error = 1'b1;
      end
    end
  end

  // Frame shifts toward bit 0 so LTC bit k lands in sr[k] once the frame completes
  genvar gi;
  generate
    for (gi = 0; gi < 79; gi++) begin : g_shift
      assign sr_next[gi] = sr_reg[gi + 1];
    end
  endgenerate
  assign sr_next[79] = shift_bit;

  assign bit_cnt_next = (bit_cnt_reg == BIT_SAT) ? BIT_SAT : bit_cnt_reg + 7'd1;
  assign sync_hit     = shift_en && (sr_next[79:64] == SYNC_WORD);

  // Two-flop synchronizer plus a registered either-edge strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
      edge_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[1:0], timecode};
      edge_reg <= sync_reg[1] ^ sync_reg[2];
    end
  end

  // Cycles since the last edge strobe, held at full scale on a dead line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      interval_reg <= '0;
    end else if (edge_reg) begin
      interval_reg <= '0;
    end else if (interval_reg != CNT_MAX) begin
      interval_reg <= interval_reg + 16'd1;
    end
  end

  // Bit-cell FSM, frame assembly, sync handling and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_BIT;
      bit_cnt_reg <= BIT_SAT;
      sr_reg      <= '0;
      hours       <= '0;
      minutes     <= '0;
      seconds     <= '0;
      frames      <= '0;
      drop_frame  <= 1'b0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (bit_error) begin
        // Saturating the count means the next sync only realigns, never loads
        state_reg   <= S_BIT;
        bit_cnt_reg <= BIT_SAT;
        locked      <= 1'b0;
      end else if (shift_en) begin
        state_reg <= S_BIT;
        sr_reg    <= sr_next;
        if (sync_hit) begin
          bit_cnt_reg <= '0;
          if (bit_cnt_next == FRAME_LEN) begin
            frames      <= {sr_next[9:8], sr_next[3:0]};
            seconds     <= {sr_next[26:24], sr_next[19:16]};
            minutes     <= {sr_next[42:40], sr_next[35:32]};
            hours       <= {sr_next[57:56], sr_next[51:48]};
            drop_frame  <= sr_next[10];
            frame_valid <= 1'b1;
            locked      <= 1'b1;
          end else begin
            locked <= 1'b0;
          end
        end else begin
          bit_cnt_reg <= bit_cnt_next;
          if (bit_cnt_next == OVERRUN) begin
            locked <= 1'b0;
          end
        end
      end else if (edge_reg && (state_reg == S_BIT) && is_short) begin
        state_reg <= S_HALF;
      end
    end
  end

endmodule

// File: tb/tb_ltc_reader.sv
// tb_ltc_reader: drives biphase-mark LTC frames into ltc_reader and checks the
// decoded pulses against a frame-level model of what a reader should report.
module tb_ltc_reader;

  localparam int CLK_HZ      = 48_000;
  localparam int TIMEOUT_CYC = CLK_HZ / 960;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b1;
  logic       timecode = 1'b0;
  logic [5:0] hours;
  logic [6:0] minutes;
  logic [6:0] seconds;
  logic [5:0] frames;
  logic       drop_frame;
  logic       frame_valid;
  logic       locked;

  ltc_reader #(.CLK_HZ(CLK_HZ)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .timecode    (timecode),
    .hours       (hours),
    .minutes     (minutes),
    .seconds     (seconds),
    .frames      (frames),
    .drop_frame  (drop_frame),
    .frame_valid (frame_valid),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] h;
    logic [6:0] m;
    logic [6:0] s;
    logic [5:0] f;
    logic       df;
  } tc_t;

  typedef struct packed {
    logic [31:0] cyc;
    tc_t         tc;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         got_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ncyc = '0;
  int          half_a = 12;
  int          half_b = 12;
  // model: synced = a clean sync has been seen; pending = a whole frame was sent
  bit          synced = 1'b0;
  bit          pending_valid = 1'b0;
  tc_t         pending_tc = '0;

  always @(posedge clk) ncyc <= ncyc + 32'd1;

  always @(negedge clk)
    if (frame_valid === 1'b1)
      got_q.push_back({ncyc, hours, minutes, seconds, frames, drop_frame});

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", ncyc);
    $fatal(1);
  end

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic tc_t make_tc(input int h, input int m, input int s, input int f, input logic df);
    logic [7:0] hb = bcd(h);
    logic [7:0] mb = bcd(m);
    logic [7:0] sb = bcd(s);
    logic [7:0] fb = bcd(f);
    return {hb[5:0], mb[6:0], sb[6:0], fb[5:0], df};
  endfunction

  // LTC frame in transmission order: index k is the k-th bit on the wire
  function automatic logic [79:0] encode(input tc_t t);
    logic [79:0] fr = '0;
    logic [15:0] sync_seq = 16'b0011_1111_1111_1101;  // bits 64..79, MSB first
    fr[3:0]   = t.f[3:0];
    fr[9:8]   = t.f[5:4];
    fr[10]    = t.df;
    fr[19:16] = t.s[3:0];
    fr[26:24] = t.s[6:4];
    fr[35:32] = t.m[3:0];
    fr[42:40] = t.m[6:4];
    fr[51:48] = t.h[3:0];
    fr[57:56] = t.h[5:4];
    for (int k = 0; k < 16; k++) fr[64 + k] = sync_seq[15 - k];
    return fr;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_fps(input int fps);
    case (fps)
      30:      begin half_a = 10; half_b = 10; end
      24:      begin half_a = 12; half_b = 13; end
      default: begin half_a = 12; half_b = 12; end
    endcase
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    synced = 1'b0;
    pending_valid = 1'b0;
    exp_q.delete();
    got_q.delete();
    tick(20);
  endtask

  // Cell-opening transition; when it follows a whole frame it completes that frame's sync
  task automatic open_cell(input bit first);
    timecode = ~timecode;
    if (first && pending_valid) begin
      if (synced) exp_q.push_back({ncyc + 32'd4, pending_tc});
      synced = 1'b1;
      pending_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input tc_t t, input int stop_at, input int glitch_at);
    logic [79:0] fr = encode(t);
    for (int i = 0; i < 80; i++) begin
      if (i == stop_at) return;
      open_cell(i == 0);
      if (i == glitch_at) begin
        tick(8);
        timecode = ~timecode;
        tick(2);
        timecode = ~timecode;
        tick(half_a + half_b - 10);
        synced = 1'b0;
      end else if (fr[i]) begin
        tick(half_a);
        timecode = ~timecode;
        tick(half_b);
      end else begin
        tick(half_a + half_b);
      end
    end
    pending_tc = t;
    pending_valid = 1'b1;
  endtask

  task automatic close_stream();
    open_cell(1'b1);
    tick(8);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({hours, minutes, seconds, frames, drop_frame, frame_valid, locked} !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {hours, minutes, seconds, frames, drop_frame, frame_valid, locked});
    end
    tick(3);
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic_25fps();
    set_fps(25);
    apply_reset();
    send_frame(make_tc(12, 34, 56, 6, 1'b0), -1, -1);
    send_frame(make_tc(12, 34, 56, 7, 1'b0), -1, -1);
    close_stream();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_event%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if ({hours, minutes, seconds, frames} !== {6'h12, 7'h34, 7'h56, 6'h07}) begin
      errors++;
      $display("FAIL basic_fields got %h:%h:%h:%h want 12:34:56:07", hours, minutes, seconds, frames);
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL basic_locked got %b want 1", locked);
    end
  endtask

  task automatic test_polarity();
    int fps_list[2] = '{30, 24};
    for (int k = 0; k < 2; k++) begin
      set_fps(fps_list[k]);
      timecode = 1'b1;
      apply_reset();
      send_frame(make_tc(12, 34, 56, 6, 1'b0), -1, -1);
      send_frame(make_tc(12, 34, 56, 7, 1'b0), -1, -1);
      close_stream();
      checks++;
      if (got_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL polarity_count fps=%0d got %0d want %0d", fps_list[k], got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL polarity_event fps=%0d got %h want %h", fps_list[k], got_q[i], exp_q[i]);
        end
      end
      checks++;
      if ({hours, minutes, seconds, frames, locked} !== {6'h12, 7'h34, 7'h56, 6'h07, 1'b1}) begin
        errors++;
        $display("FAIL polarity_fields fps=%0d got %h:%h:%h:%h lk=%b want 12:34:56:07 lk=1", fps_list[k], hours, minutes, seconds, frames, locked);
      end
    end
  endtask

  task automatic test_glitch();
    set_fps(25);
    apply_reset();
    send_frame(make_tc(1, 2, 3, 4, 1'b0), -1, -1);
    send_frame(make_tc(1, 2, 3, 5, 1'b0), -1, -1);
    send_frame(make_tc(1, 2, 3, 6, 1'b0), -1, 44);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL glitch_unlock got %b want 0", locked);
    end
    send_frame(make_tc(1, 2, 3, 7, 1'b0), -1, -1);
    close_stream();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL glitch_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL glitch_event%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL glitch_relock got %b want 1", locked);
    end
  endtask

  task automatic test_timeout();
    set_fps(25);
    apply_reset();
    send_frame(make_tc(23, 59, 58, 24, 1'b0), -1, -1);
    send_frame(make_tc(23, 59, 59, 24, 1'b0), -1, -1);
    close_stream();
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL timeout_prelock got %b want 1", locked);
    end
    tick(2 * TIMEOUT_CYC);
    synced = 1'b0;
    pending_valid = 1'b0;
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL timeout_unlock got %b want 0", locked);
    end
    checks++;
    if ({hours, minutes, seconds, frames} !== {6'h23, 7'h59, 7'h59, 6'h24}) begin
      errors++;
      $display("FAIL timeout_hold got %h:%h:%h:%h want 23:59:59:24", hours, minutes, seconds, frames);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL timeout_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL timeout_event%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    set_fps(25);
    apply_reset();
    send_frame(make_tc(10, 20, 30, 10, 1'b0), -1, -1);
    send_frame(make_tc(10, 20, 30, 11, 1'b0), -1, -1);
    send_frame(make_tc(10, 20, 30, 12, 1'b0), 40, -1);
    checks++;
    if (got_q.size() != exp_q.size() || got_q.size() == 0 || got_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL midreset_pre got n=%0d want n=%0d", got_q.size(), exp_q.size());
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({hours, minutes, seconds, frames, drop_frame, frame_valid, locked} !== 29'd0) begin
      errors++;
      $display("FAIL midreset_zero got %h want 0", {hours, minutes, seconds, frames, drop_frame, frame_valid, locked});
    end
    tick(3);
    reset_n = 1'b1;
    synced = 1'b0;
    pending_valid = 1'b0;
    exp_q.delete();
    got_q.delete();
    tick(20);
    send_frame(make_tc(10, 20, 31, 0, 1'b0), -1, -1);
    send_frame(make_tc(10, 20, 31, 1, 1'b0), -1, -1);
    send_frame(make_tc(10, 20, 31, 2, 1'b0), -1, -1);
    close_stream();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL midreset_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midreset_event%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_drop_frame();
    set_fps(30);
    apply_reset();
    send_frame(make_tc(1, 0, 0, 2, 1'b1), -1, -1);
    send_frame(make_tc(1, 0, 0, 3, 1'b1), -1, -1);
    close_stream();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL drop_event got n=%0d want n=1 ev=%h", got_q.size(), exp_q[0]);
    end
    checks++;
    if (drop_frame !== 1'b1) begin
      errors++;
      $display("FAIL drop_flag got %b want 1", drop_frame);
    end
  endtask

  task automatic test_back_to_back();
    int fps_list[3] = '{24, 25, 30};
    set_fps(fps_list[$urandom_range(0, 2)]);
    timecode = 1'($urandom_range(0, 1));
    apply_reset();
    for (int n = 0; n < 5; n++)
      send_frame(make_tc($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59),
                         $urandom_range(0, 29), 1'($urandom_range(0, 1))), -1, -1);
    close_stream();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_event%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_25fps();
    test_polarity();
    test_glitch();
    test_timeout();
    test_reset_midframe();
    test_drop_frame();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
